// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit between a CPU request port and
// a word-wide memory with combinational read data. Sub-word stores use a
// read-modify-write sequence so that unaddressed bytes are written back intact.
// Optional build macro LSU_MISALIGN_CHECK_EN: misaligned or illegal-size
// accesses bypass memory and complete with misalign_err; without it, low
// address bits are ignored and size 11 behaves as a word access.
module lsu_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_err,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WRITE, S_RMW_READ, S_RMW_WRITE, S_RESP
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] wdata_q, wdata_d;   // store data, replaced by the merged word during RMW
    logic [31:0] rdata_q, rdata_d;   // last load result
    logic [1:0]  acc_size;
    logic        acc_err;
    logic        req_fire;
    logic [31:0] aligned_a;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    res = {{24{sgn & b[7]}}, b};
            SZ_H:    res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Overlay the store data onto the old word, keeping unaddressed bytes.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            SZ_B: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                data = {24'b0, wdata[7:0]} << {lane, 3'b000};
            end
            SZ_H: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                data = {16'b0, wdata[15:0]} << {lane[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        return (old & ~mask) | (data & mask);
    endfunction

    assign req_fire  = req_valid && (state_q == S_IDLE);
    assign aligned_a = {addr_q[31:2], 2'b00};

    // Classify the incoming request: effective size and whether it must be rejected.
    always_comb begin
        acc_size = req_size;
        acc_err  = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        acc_err = ((req_size == SZ_H) && req_addr[0]) ||
                  ((req_size == SZ_W) && (req_addr[1:0] != 2'b00)) ||
                  (req_size == 2'b11);
`else
        if (req_size == 2'b11) acc_size = SZ_W;
`endif
    end

    // State and request/result registers; reset clears everything so a dropped request leaves no trace.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            we_q    <= we_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state sequencing: route each request to load, word store, RMW store or direct error response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    if (acc_err)              state_d = S_RESP;
                    else if (!req_we)         state_d = S_READ;
                    else if (acc_size == SZ_W) state_d = S_WRITE;
                    else                      state_d = S_RMW_READ;
                end
            end
            S_READ:      state_d = S_RESP;
            S_WRITE:     state_d = S_RESP;
            S_RMW_READ:  state_d = S_RMW_WRITE;
            S_RMW_WRITE: state_d = S_RESP;
            S_RESP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Request latch on acceptance, load capture in READ, merge capture in RMW_READ.
    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        we_d    = we_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (req_fire) begin
            addr_d  = req_addr;
            size_d  = acc_size;
            sgn_d   = req_signed;
            we_d    = req_we;
            err_d   = acc_err;
            wdata_d = req_wdata;
        end
        case (state_q)
            S_READ:     rdata_d = load_extract(mem_rd, addr_q[1:0], size_q, sgn_q);
            S_RMW_READ: wdata_d = store_merge(mem_rd, wdata_q, addr_q[1:0], size_q);
            default: ;
        endcase
    end

    // Outputs decoded from state; mem_we and the response are forced low while reset is held.
    always_comb begin
        req_ready    = reset_n && (state_q == S_IDLE);
        resp_valid   = 1'b0;
        resp_rdata   = rdata_q;
        misalign_err = 1'b0;
        mem_a        = '0;
        mem_we       = 1'b0;
        mem_wd       = '0;
        case (state_q)
            S_READ, S_RMW_READ: mem_a = aligned_a;
            S_WRITE, S_RMW_WRITE: begin
                mem_a  = aligned_a;
                mem_we = reset_n;
                mem_wd = wdata_q;
            end
            S_RESP: begin
                resp_valid = reset_n;
                if (we_q || err_q) resp_rdata = '0;
`ifdef LSU_MISALIGN_CHECK_EN
                misalign_err = reset_n && err_q;
`endif
            end
            default: ;
        endcase
    end

endmodule
